ln_vec_streamer: RTL and testbench
==================================

# ln_vec_streamer

Source and replay engine for the LayerNorm mean path. It holds one token vector of N_ELEM signed elements and streams it to the Ex (mean) unit as a valid/data stream. It then waits for the unit's done strobe and captures the mean. Finally it replays the same vector as mean-centred values (x − E[x]) for the downstream variance/normalise stage.

## Interface

Parameters:

- N_ELEM, 8: elements per token vector, ≥2
- DATA_W, 8: element width, signed
- TIMEOUT, 64: maximum cycles to wait for the Ex done strobe, ≥1

Ports:

- i_clk  in  1  clock; all state changes on its rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_wr_en  in  1  buffer write strobe
- i_wr_addr  in  clog2(N_ELEM)  buffer write index
- i_wr_data  in  DATA_W  signed element to store
- i_start  in  1  begin one stream/replay sequence
- i_ex_done  in  1  done strobe from the Ex unit
- i_ex  in  DATA_W+1  signed mean from the Ex unit, valid with i_ex_done
- o_valid  out  1  element valid to the Ex unit
- o_x  out  DATA_W  signed element to the Ex unit
- o_c_valid  out  1  centred value valid
- o_centered  out  DATA_W+2  signed x − mean
- o_mean  out  DATA_W+1  captured mean, held until next capture or reset
- o_busy  out  1  high whenever state ≠ IDLE
- o_done  out  1  one-cycle pulse at sequence end
- o_err  out  1  one-cycle pulse on Ex timeout

## Operation

States: IDLE, STREAM, WAIT_EX, REPLAY, DONE.

- **IDLE**
  - i_wr_en writes i_wr_data to buf[i_wr_addr].
  - Addresses ≥ N_ELEM are dropped.
  - i_start → STREAM, element index reset to 0.
- **STREAM**
  - Presents buf[0..N_ELEM−1] in order, one per cycle, with o_valid high.
  - After the last element → WAIT_EX, wait counter reset to 0.
- **WAIT_EX**
  - i_ex_done high: capture i_ex into o_mean, then → REPLAY with index 0.
  - Otherwise the counter increments.
  - After TIMEOUT cycles without done → IDLE and o_err pulses.
- **REPLAY**
  - Presents o_centered = sext(buf[i]) − sext(o_mean) for i = 0..N_ELEM−1, one per cycle, with o_c_valid high.
  - After the last element → DONE.
- **DONE**
  - o_done high for one cycle, then → IDLE.

Arithmetic: the subtraction is full-precision at DATA_W+2 bits. The range is ±(2^(DATA_W−1) + 2^DATA_W), so there is never saturation or wrap.

Boundary rules:

- i_wr_en outside IDLE is ignored, so the buffer is stable for both passes.
- i_start outside IDLE is ignored. i_start and i_wr_en together in IDLE: the write completes and the stream starts, and that element already carries the new value when read.
- i_ex_done outside WAIT_EX is ignored; a spurious done during STREAM does not shorten the stream.
- i_ex_done on the last WAIT_EX cycle (counter = TIMEOUT−1) counts as success; o_err stays low.
- The buffer is not cleared on completion. A second i_start replays the same contents.
- i_rst asserted at any time, mid-sequence included:
  - state → IDLE immediately; buf, o_mean and all outputs → 0.
  - No o_done or o_err is produced for the aborted sequence.

## Timing

- All outputs are registered.
- Reset value of every output is 0: o_valid, o_x, o_c_valid, o_centered, o_mean, o_busy, o_done, o_err.
- i_start sampled at edge k:
  - o_valid high for cycles k+1 … k+N_ELEM, with o_x = buf[0] … buf[N_ELEM−1].
  - o_valid is low at k+N_ELEM+1.
  - o_busy is high from k+1.
- WAIT_EX begins at cycle k+N_ELEM+1.
- i_ex_done sampled at edge j:
  - o_mean updates at j.
  - o_c_valid high for cycles j+1 … j+N_ELEM.
  - o_done is high at j+N_ELEM+1.
  - o_busy is low from j+N_ELEM+2.
- Timeout: o_err is high in the cycle after the TIMEOUT-th WAIT_EX cycle, and o_busy is low in that same cycle.
- o_x and o_centered hold their last value while their valid is low. Consumers qualify them with valid only.
- Minimum sequence length, done on the first WAIT_EX cycle: 2·N_ELEM+2 cycles from the start edge to o_busy low.

## Test plan

- Reset: assert i_rst mid-clock with no edge → all outputs 0 immediately; o_busy 0 after release.
- Stream: load buf = 1,2,…,8, pulse i_start → o_valid for exactly 8 consecutive cycles, o_x = 1..8, then low; o_busy high.
- Replay: 3 WAIT_EX cycles, then i_ex_done with i_ex = 5 → o_mean = 5; o_centered = −4,−3,…,3 over 8 cycles; o_done 1 cycle later, single pulse.
- Extremes: buf all −128, i_ex = +255 → o_centered = −383 ×8. Then buf all 127, i_ex = −256 → o_centered = +383 ×8.
- Timeout: TIMEOUT = 16, never assert i_ex_done → o_err pulses once, 16 cycles after WAIT_EX entry. o_c_valid and o_done are never asserted, and o_busy is low.
- Illegal/abort:
  - i_start, i_wr_en and i_ex_done pulsed during STREAM → stream unchanged, buffer unchanged, spurious done ignored.
  - i_rst at the 4th REPLAY cycle → o_c_valid drops immediately, and no o_done follows.

Source files
------------

// File: rtl/ln_vec_streamer.sv
// ln_vec_streamer
//   Source/replay engine for the LayerNorm mean path. Holds one token vector,
//   streams it to the Ex (mean) unit, captures the returned mean, then replays
//   the same vector as mean-centred values x - E[x].
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_wr_en      buffer write strobe (honoured in IDLE only)
//   i_wr_addr    buffer write index (indices >= N_ELEM are dropped)
//   i_wr_data    signed element to store
//   i_start      begin one stream/replay sequence (honoured in IDLE only)
//   i_ex_done    done strobe from the Ex unit (honoured in WAIT_EX only)
//   i_ex         signed mean from the Ex unit, valid with i_ex_done
//   o_valid      element valid to the Ex unit
//   o_x          signed element to the Ex unit
//   o_c_valid    centred value valid
//   o_centered   signed x - mean, full precision
//   o_mean       captured mean, held until next capture or reset
//   o_busy       high whenever the sequencer is not idle
//   o_done       one-cycle pulse at sequence end
//   o_err        one-cycle pulse when the Ex unit times out
module ln_vec_streamer #(
    parameter int N_ELEM  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [$clog2(N_ELEM)-1:0]   i_wr_addr,
    input  logic signed [DATA_W-1:0]    i_wr_data,
    input  logic                        i_start,
    input  logic                        i_ex_done,
    input  logic signed [DATA_W:0]      i_ex,
    output logic                        o_valid,
    output logic signed [DATA_W-1:0]    o_x,
    output logic                        o_c_valid,
    output logic signed [DATA_W+1:0]    o_centered,
    output logic signed [DATA_W:0]      o_mean,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err
);

    localparam int AW  = $clog2(N_ELEM);
    localparam int CW  = $clog2(N_ELEM + 1);   // index counts up to N_ELEM inclusive
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int CXW = DATA_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT_EX,
        REPLAY,
        DONE
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            idx_q;
    logic [TW-1:0]            wcnt_q;
    logic signed [DATA_W-1:0] buf_q [N_ELEM];

    logic                     valid_q;
    logic signed [DATA_W-1:0] x_q;
    logic                     c_valid_q;
    logic signed [CXW-1:0]    cent_q;
    logic signed [DATA_W:0]   mean_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;

    logic                     wr_ok_d;
    logic signed [DATA_W-1:0] first_d;
    logic signed [DATA_W-1:0] rd_d;
    logic signed [CXW-1:0]    cent_first_d;
    logic signed [CXW-1:0]    cent_d;
    logic                     idx_end_d;
    logic                     tmo_d;

    always_comb begin
        wr_ok_d      = i_wr_en && (int'(i_wr_addr) < N_ELEM);
        // A write landing on element 0 in the start cycle must be seen by the
        // very first streamed element, so forward it around the buffer.
        first_d      = (wr_ok_d && (i_wr_addr == '0)) ? i_wr_data : buf_q[0];
        rd_d         = buf_q[idx_q[AW-1:0]];
        // First centred value uses the mean arriving this cycle, since mean_q
        // is only being loaded on the same edge.
        cent_first_d = {{2{buf_q[0][DATA_W-1]}}, buf_q[0]} - {i_ex[DATA_W], i_ex};
        cent_d       = {{2{rd_d[DATA_W-1]}}, rd_d} - {mean_q[DATA_W], mean_q};
        idx_end_d    = (idx_q == CW'(N_ELEM));
        tmo_d        = (wcnt_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wcnt_q    <= '0;
            for (int i = 0; i < N_ELEM; i++) buf_q[i] <= '0;
            valid_q   <= 1'b0;
            x_q       <= '0;
            c_valid_q <= 1'b0;
            cent_q    <= '0;
            mean_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_ok_d) buf_q[i_wr_addr] <= i_wr_data;
                    if (i_start) begin
                        state_q <= STREAM;
                        valid_q <= 1'b1;
                        x_q     <= first_d;
                        idx_q   <= CW'(1);
                        busy_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (!idx_end_d) begin
                        valid_q <= 1'b1;
                        x_q     <= rd_d;
                        idx_q   <= idx_q + CW'(1);
                    end else begin
                        valid_q <= 1'b0;
                        wcnt_q  <= '0;
                        state_q <= WAIT_EX;
                    end
                end
                WAIT_EX: begin
                    // Done on the final counted cycle still wins over timeout.
                    if (i_ex_done) begin
                        mean_q    <= i_ex;
                        c_valid_q <= 1'b1;
                        cent_q    <= cent_first_d;
                        idx_q     <= CW'(1);
                        state_q   <= REPLAY;
                    end else if (tmo_d) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + TW'(1);
                    end
                end
                REPLAY: begin
                    if (!idx_end_d) begin
                        c_valid_q <= 1'b1;
                        cent_q    <= cent_d;
                        idx_q     <= idx_q + CW'(1);
                    end else begin
                        c_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_valid    = valid_q;
    assign o_x        = x_q;
    assign o_c_valid  = c_valid_q;
    assign o_centered = cent_q;
    assign o_mean     = mean_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_ln_vec_streamer.sv
module tb_ln_vec_streamer;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 wr_en = 1'b0;
    logic [2:0]           wr_addr = '0;
    logic signed [W-1:0]  wr_data = '0;
    logic                 start = 1'b0;
    logic                 ex_done = 1'b0;
    logic signed [W:0]    ex = '0;
    logic                 o_valid;
    logic signed [W-1:0]  o_x;
    logic                 o_c_valid;
    logic signed [W+1:0]  o_centered;
    logic signed [W:0]    o_mean;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;

    ln_vec_streamer #(.N_ELEM(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start), .i_ex_done(ex_done), .i_ex(ex),
        .o_valid(o_valid), .o_x(o_x), .o_c_valid(o_c_valid),
        .o_centered(o_centered), .o_mean(o_mean), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int nvec = 0, nmis = 0, ndone = 0, nerr = 0, exp_done = 0;
    int bufm[N];
    int qx[$];
    int qc[$];

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // output monitor: scoreboard pops
    always @(negedge clk) begin
        if (o_valid) begin
            if (qx.size() == 0) chk("x_extra", 32'(o_valid), 32'(qx.size() != 0));
            else chk("x", o_x, qx.pop_front());
        end
        if (o_c_valid) begin
            if (qc.size() == 0) chk("c_extra", 32'(o_c_valid), 32'(qc.size() != 0));
            else chk("centered", o_centered, qc.pop_front());
        end
        if (o_done) ndone++;
        if (o_err) nerr++;
    end

    task automatic load(input int base, input int step);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = W'(base + step * i);
            bufm[i] = base + step * i;
        end
        @(negedge clk); wr_en = 1'b0;
    endtask

    // w = WAIT_EX cycles before done; w >= TO means never send done
    task automatic run(input int m, input int w, input bit spur, input bit fwd, input bit abort);
        int n;
        @(negedge clk);
        if (fwd) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = 8'sd77; bufm[0] = 77;
        end
        for (int i = 0; i < N; i++) qx.push_back(bufm[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        chk("busy_run", 32'(o_busy), 1);
        n = 0;
        if (spur) begin
            @(negedge clk);
            start = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'sd99; ex_done = 1'b1; ex = 9'sd7;
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0; ex_done = 1'b0;
        end
        while (o_valid && n < 40) begin @(negedge clk); n++; end
        chk("stream_len", n, spur ? N - 2 : N);
        chk("x_drain", qx.size(), 0);
        if (w >= TO) begin
            n = 0;
            while (!o_err && n < 60) begin @(negedge clk); n++; end
            chk("err_lat", n, TO);
            chk("busy_err", 32'(o_busy), 0);
            @(negedge clk);
            chk("err_pulse", 32'(o_err), 0);
            return;
        end
        repeat (w) @(negedge clk);
        for (int i = 0; i < N; i++) qc.push_back(bufm[i] - m);
        ex_done = 1'b1; ex = 9'(m);
        @(negedge clk);
        ex_done = 1'b0;
        chk("mean", o_mean, m);
        chk("cvalid_1st", 32'(o_c_valid), 1);
        if (abort) begin
            @(negedge clk);
            @(negedge clk);
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("abort_cvalid", 32'(o_c_valid), 0);
            chk("abort_busy", 32'(o_busy), 0);
            chk("abort_mean", o_mean, 0);
            chk("abort_left", qc.size(), N - 3);
            qc.delete();
            for (int i = 0; i < N; i++) bufm[i] = 0;
            @(negedge clk); rst = 1'b0;
            repeat (N + 4) @(negedge clk);
            chk("abort_nodone", ndone, exp_done);
            return;
        end
        n = 0;
        while (!o_done && n < 40) begin @(negedge clk); n++; end
        chk("done_lat", n, N);
        chk("c_drain", qc.size(), 0);
        exp_done++;
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 0);
        chk("busy_end", 32'(o_busy), 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) bufm[i] = 0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_x", o_x, 0);
        chk("rst_cvalid", 32'(o_c_valid), 0);
        chk("rst_cent", o_centered, 0);
        chk("rst_mean", o_mean, 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_err), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("busy_idle", 32'(o_busy), 0);

        load(1, 1);      run(5, 3, 0, 0, 0);       // -4..3
        load(-128, 0);   run(255, 0, 0, 0, 0);     // -383, done on first WAIT_EX cycle
        load(127, 0);    run(-256, 5, 0, 0, 0);    // +383
        load(-50, 13);   run(-7, TO - 1, 0, 0, 0); // done on last permitted cycle
        run(0, TO, 0, 0, 0);                       // timeout
        run(3, 2, 1, 0, 0);                        // spurious inputs during stream
        run(-1, 1, 0, 1, 0);                       // start + write to element 0
        run(20, 2, 0, 0, 0);                       // buffer retained, replay again
        run(9, 1, 0, 0, 1);                        // reset mid-replay
        run(-3, 0, 0, 0, 0);                       // buffer cleared by reset

        chk("done_cnt", ndone, exp_done);
        chk("err_cnt", nerr, 1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
